arith_arbiter: RTL
==================

# arith_arbiter

Shared-resource scheduler for the 4-bit arithmetic/logic/compare datapath. Several requesters each present an operation code and two operands. A round-robin arbiter accepts one request at a time and executes it: logic, add, subtract and compare in one cycle, multiply as a W-cycle shift-add sequence. The tagged result is held on a valid/ready response port until consumed. It sits between client blocks and the single arithmetic resource, so that resource can be shared without duplicating the multiplier.

## Interface
- NREQ, 4: number of requesters (2..8).
- W, 4: operand width in bits; results are 2W bits.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_op  in  4*NREQ  op code; requester i uses bits [4i+3:4i].
- req_a, req_b  in  W*NREQ  operands; requester i uses bits [Wi+W-1:Wi].
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  clog2(NREQ)  index of the requester that issued the result.
- rsp_data  out  2W  result.
- rsp_err  out  1  op code was reserved.

## Operation
- Op codes:
  - 0: logical AND (a!=0 && b!=0).
  - 1: logical OR.
  - 2: bitwise AND.
  - 3: bitwise OR.
  - 4: bitwise XOR.
  - 5: add.
  - 6: subtract.
  - 7: multiply.
  - 8–13: compare, in order eq, ne, lt, le, ge, gt.
  - 14, 15: reserved.
- Operands are unsigned.
- Result width rules:
  - Bitwise and logical results and compare results are zero-extended to 2W bits.
  - add = a+b zero-extended (carry lands in bit W).
  - sub = (a-b) mod 2^(2W), i.e. the borrow sign-extends.
  - mul = full 2W-bit product.
  - Reserved op codes give rsp_data=0 and rsp_err=1; otherwise rsp_err=0.
- FSM states:
  - IDLE: if any req_valid is set, assert req_ready for the round-robin winner only. On the handshake, latch op, a, b and the requester id, and advance the pointer to winner+1 mod NREQ. Go to MUL if op=7; otherwise compute the result into the output register and go to HOLD.
  - MUL: iterate W cycles. Each cycle, if multiplier bit k is set, add a<<k to the accumulator. After W cycles, go to HOLD.
  - HOLD: rsp_valid=1 with data, id and err stable. When rsp_ready=1, go to IDLE.
- Arbitration:
  - Round-robin starting from the pointer; the lowest index at or after the pointer wins.
  - The pointer moves only on an accepted request.
  - req_ready is 0 in MUL and HOLD.
  - A requester holds its op and operands stable while req_valid is set and it has not been accepted.
- Requesters may raise or drop req_valid at any time before acceptance; only the current-cycle valid is considered.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, pointer=0, state IDLE.
- Reset asserted in MUL or HOLD aborts the operation; the pending result is discarded.
- req_ready is combinational from req_valid and the pointer in IDLE. No combinational path from rsp_ready to req_ready.
- Latency from the accept edge:
  - Non-mul: rsp_valid rises on the next edge, i.e. 1 cycle.
  - mul: rsp_valid rises W+1 cycles later.
- HOLD lasts at least 1 cycle. rsp_valid drops on the edge where rsp_ready was sampled high.
- IDLE lasts at least 1 cycle between results. Peak throughput is one non-mul result per 2 cycles; a mul takes W+2 cycles.
- rsp_ready held low keeps the result stable indefinitely. No new request is accepted in that time.

## Test plan
- Reset, then single request:
  - Stimulus: requester 0, op=5, a=4'hF, b=4'h1.
  - Response: 1 cycle after accept, rsp_valid=1, rsp_data=8'h10, rsp_id=0, rsp_err=0.
- Subtract and multiply, each issued by requester 2:
  - op=6, a=3, b=5: rsp_data=8'hFE.
  - op=7, a=4'hF, b=4'hF: rsp_data=8'hE1 exactly 5 cycles after accept, with req_ready=0 throughout.
- Round-robin fairness:
  - Stimulus: all four requesters hold req_valid continuously with rsp_ready=1.
  - Response: grant order is 0,1,2,3,0,1; each grant is 2 cycles apart for non-mul ops.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles after a compare op=10, a=2, b=9.
  - Response: rsp_data=8'h01 is stable and no req_ready is asserted until rsp_ready=1.
- Reserved op and reset mid-mul:
  - op=14: rsp_err=1, rsp_data=0.
  - Assert rst 2 cycles into a mul: all outputs 0 immediately, pointer=0, and the next request is granted to the lowest valid index.
- Exhaustive compare/logic sweep:
  - Stimulus: all a, b in 0..15 for ops 0–4 and 8–13.
  - Response: rsp_data matches the unsigned reference model.

Source files
------------

// File: rtl/arith_arbiter.sv
// arith_arbiter: round-robin scheduler in front of a shared 4-bit
// arithmetic/logic/compare unit. One request is accepted at a time.
// Single-cycle ops land straight in the response register. Multiply runs as
// a W-cycle shift-add sequence. The tagged result is held until consumed.
module arith_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [4*NREQ-1:0]        req_op,
  input  logic [W*NREQ-1:0]        req_a,
  input  logic [W*NREQ-1:0]        req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*W-1:0]           rsp_data,
  output logic                     rsp_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [2*W-1:0] data_q, data_d;
  logic           err_q, err_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [3:0]     op_arr [NREQ];
  logic [W-1:0]   a_arr  [NREQ];
  logic [W-1:0]   b_arr  [NREQ];

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand_idx;
  logic [3:0]     win_op;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;
  logic           accept;
  int             cand;

  // Single-cycle ALU: logical, bitwise, add, subtract, compare. Multiply and
  // reserved codes return zero here; multiply is handled by the MUL state.
  function automatic logic [2*W-1:0] alu_f(input logic [3:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    logic [2*W-1:0] r;
    ax = {{W{1'b0}}, a};
    bx = {{W{1'b0}}, b};
    r  = '0;
    case (op)
      4'd0:    r[0] = (a != '0) && (b != '0);
      4'd1:    r[0] = (a != '0) || (b != '0);
      4'd2:    r = ax & bx;
      4'd3:    r = ax | bx;
      4'd4:    r = ax ^ bx;
      4'd5:    r = ax + bx;
      4'd6:    r = ax - bx;  // borrow wraps through the upper W bits
      4'd8:    r[0] = (a == b);
      4'd9:    r[0] = (a != b);
      4'd10:   r[0] = (a <  b);
      4'd11:   r[0] = (a <= b);
      4'd12:   r[0] = (a >= b);
      4'd13:   r[0] = (a >  b);
      default: r = '0;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[4*g +: 4];
    assign a_arr[g]  = req_a[W*g +: W];
    assign b_arr[g]  = req_b[W*g +: W];
  end

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_op    = '0;
    win_a     = '0;
    win_b     = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
        win_op    = op_arr[cand_idx];
        win_a     = a_arr[cand_idx];
        win_b     = b_arr[cand_idx];
      end
    end
  end

  assign accept = (state_q == S_IDLE) && win_found && !rst;

  // Grant is offered only in IDLE; it never depends on rsp_ready.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  // Next-state logic for the IDLE -> (MUL) -> HOLD sequence.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d  = win_idx;
          ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          if (win_op == 4'd7) begin
            data_d   = '0;
            err_d    = 1'b0;
            mcand_d  = {{W{1'b0}}, win_a};
            mplier_d = win_b;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            data_d  = alu_f(win_op, win_a, win_b);
            err_d   = (win_op >= 4'd14);
            state_d = S_HOLD;
          end
        end
      end
      S_MUL: begin
        // One multiplier bit per cycle; the result register is the accumulator.
        if (mplier_q[0]) data_d = data_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      data_q   <= data_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == S_HOLD);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule
